// File: rtl/cache_port_arbiter_if.sv
// Requester-side handshake bundle for one cache_port_arbiter port.
// master = requester driving rq_*, slave = arbiter driving rq_ready and rs_*.
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rq_valid;
  logic              rq_write;
  logic [ADDR_W-1:0] rq_addr;
  logic [DATA_W-1:0] rq_wdata;
  logic              rq_ready;
  logic              rs_valid;
  logic [DATA_W-1:0] rs_rdata;
  logic              rs_hit;
  logic              rs_err;

  modport master (
    output rq_valid, rq_write, rq_addr, rq_wdata,
    input  rq_ready, rs_valid, rs_rdata, rs_hit, rs_err
  );

  modport slave (
    input  rq_valid, rq_write, rq_addr, rq_wdata,
    output rq_ready, rs_valid, rs_rdata, rs_hit, rs_err
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin share of one cache port between fetch (port 0) and load/store (port 1), with hit/miss stats and watchdog.
// Latency: accept T, cache command T+1.., response one cycle after c_done; requesters hold rq_valid until rq_ready.
module cache_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_b,
  cache_port_arbiter_if.slave  port_0,
  cache_port_arbiter_if.slave  port_1,
  output logic [ADDR_W-1:0]    c_address,
  output logic [DATA_W-1:0]    c_write_data,
  output logic                 c_read,
  output logic                 c_write,
  input  logic [DATA_W-1:0]    c_read_data,
  input  logic                 c_hit,
  input  logic                 c_miss,
  input  logic                 c_done,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [11:0]      WD_LAST = 12'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic              favour;   // port that wins a tie; starts at port 0
  logic              id;
  logic              wr;
  logic [11:0]       wdog;
  logic [1:0]        rs_vld;
  logic [DATA_W-1:0] rdata_q;
  logic              hit_q;
  logic              miss_q;
  logic              err_q;

  logic              grant;
  logic              req_any;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    grant = port_1.rq_valid;
    if (port_0.rq_valid && port_1.rq_valid) grant = favour;
  end

  assign req_any   = port_0.rq_valid | port_1.rq_valid;
  assign sel_write = grant ? port_1.rq_write : port_0.rq_write;
  assign sel_addr  = grant ? port_1.rq_addr  : port_0.rq_addr;
  assign sel_wdata = grant ? port_1.rq_wdata : port_0.rq_wdata;

  assign port_0.rq_ready = (state == IDLE) && port_0.rq_valid && !grant;
  assign port_1.rq_ready = (state == IDLE) && port_1.rq_valid &&  grant;

  // Response fields are shared; each port only sees them while its own valid is up.
  assign port_0.rs_valid = rs_vld[0];
  assign port_0.rs_rdata = rs_vld[0] ? rdata_q : '0;
  assign port_0.rs_hit   = rs_vld[0] & hit_q;
  assign port_0.rs_err   = rs_vld[0] & err_q;
  assign port_1.rs_valid = rs_vld[1];
  assign port_1.rs_rdata = rs_vld[1] ? rdata_q : '0;
  assign port_1.rs_hit   = rs_vld[1] & hit_q;
  assign port_1.rs_err   = rs_vld[1] & err_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      favour       <= 1'b0;
      id           <= 1'b0;
      wr           <= 1'b0;
      c_address    <= '0;
      c_write_data <= '0;
      c_read       <= 1'b0;
      c_write      <= 1'b0;
      wdog         <= '0;
      rs_vld       <= '0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            id           <= grant;
            wr           <= sel_write;
            c_address    <= sel_addr;
            c_write_data <= sel_wdata;
            c_read       <= !sel_write;
            c_write      <= sel_write;
            wdog         <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // A completion in the watchdog's last cycle still counts as a completion.
          if (c_done) begin
            c_read  <= 1'b0;
            c_write <= 1'b0;
            rs_vld  <= id ? 2'b10 : 2'b01;
            rdata_q <= wr ? '0 : c_read_data;
            hit_q   <= c_hit;
            miss_q  <= c_miss;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (wdog == WD_LAST) begin
            c_read  <= 1'b0;
            c_write <= 1'b0;
            rs_vld  <= id ? 2'b10 : 2'b01;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            wdog <= wdog + 12'd1;
          end
        end
        RESP: begin
          rs_vld <= '0;
          favour <= ~id;
          wdog   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clr_cnt) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == RESP && !err_q) begin
      if (hit_q) begin
        if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_W'(1);
      end else if (miss_q) begin
        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter (TIMEOUT=8, CNT_W=2): arbitration, latency, watchdog, stats, reset.
module tb_cache_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic [31:0] c_address, c_write_data, c_read_data;
  logic        c_read, c_write, c_hit, c_miss, c_done, clr_cnt;
  logic [1:0]  hit_cnt, miss_cnt;
  int          tests  = 0;
  int          failed = 0;

  cache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  cache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .port_0       (if0),
    .port_1       (if1),
    .c_address    (c_address),
    .c_write_data (c_write_data),
    .c_read       (c_read),
    .c_write      (c_write),
    .c_read_data  (c_read_data),
    .c_hit        (c_hit),
    .c_miss       (c_miss),
    .c_done       (c_done),
    .clr_cnt      (clr_cnt),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit p, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      if1.rq_valid = v; if1.rq_write = w; if1.rq_addr = a; if1.rq_wdata = d;
    end else begin
      if0.rq_valid = v; if0.rq_write = w; if0.rq_addr = a; if0.rq_wdata = d;
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? if1.rq_ready : if0.rq_ready;
  endfunction
  function automatic logic rsv(input bit p);
    return p ? if1.rs_valid : if0.rs_valid;
  endfunction
  function automatic logic [31:0] rsd(input bit p);
    return p ? if1.rs_rdata : if0.rs_rdata;
  endfunction
  function automatic logic rsh(input bit p);
    return p ? if1.rs_hit : if0.rs_hit;
  endfunction
  function automatic logic rse(input bit p);
    return p ? if1.rs_err : if0.rs_err;
  endfunction

  // One transaction from an idle arbiter. k = BUSY cycle carrying c_done (0 = never),
  // lat = cycles from accept to the response cycle.
  task automatic txn(input string tag, input bit p, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input int k, input bit hit, input bit miss,
                     input logic [31:0] rd, input bit exp_err, input int lat, input bit clr);
    logic [31:0] exp_rd;
    exp_rd = (w || exp_err) ? 32'h0 : rd;
    drive(p, 1'b1, w, a, d);
    #1;
    check({tag, " ready"}, {62'd0, rdy(p), rdy(!p)}, 64'd2);
    tick();
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i < lat; i++) begin
      c_done      = (i == k);
      c_hit       = (i == k) && hit;
      c_miss      = (i == k) && miss;
      c_read_data = (i == k) ? rd : 32'h1111_1111;
      #1;
      check({tag, " busy cmd"}, {61'd0, c_read, c_write, rsv(p)}, {61'd0, !w, w, 1'b0});
      if (i == 1) check({tag, " addr/wdata"}, {c_address, c_write_data}, {a, d});
      tick();
    end
    c_done = 1'b0; c_hit = 1'b0; c_miss = 1'b0; c_read_data = 32'h0;
    #1;
    check({tag, " rs_valid"}, {62'd0, rsv(p), rsv(!p)}, 64'd2);
    check({tag, " rs_rdata"}, {32'd0, rsd(p)}, {32'd0, exp_rd});
    check({tag, " rs_hit/err"}, {62'd0, rsh(p), rse(p)}, {62'd0, hit && !exp_err, exp_err});
    check({tag, " cmd dropped"}, {62'd0, c_read, c_write}, 64'd0);
    clr_cnt = clr;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    c_read_data = 32'h0; c_hit = 1'b0; c_miss = 1'b0; c_done = 1'b0; clr_cnt = 1'b0;
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    #1;
    check("reset cmd", {62'd0, c_read, c_write}, 64'd0);
    check("reset rs_valid", {62'd0, if0.rs_valid, if1.rs_valid}, 64'd0);
    check("reset counters", {60'd0, hit_cnt, miss_cnt}, 64'd0);
    check("reset addr", {32'd0, c_address}, 64'd0);
    tick(); tick();
    rst_b = 1'b1;
    tick();

    // Both ports held valid: strict alternation starting at port 0.
    drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    for (int r = 0; r < 3; r++) begin
      #1;
      check($sformatf("arb round %0d grant", r), {62'd0, if0.rq_ready, if1.rq_ready},
            (r % 2 == 0) ? 64'd2 : 64'd1);
      tick();
      c_done = 1'b1;
      #1;
      check($sformatf("arb round %0d busy ready", r), {62'd0, if0.rq_ready, if1.rq_ready}, 64'd0);
      tick();
      c_done = 1'b0;
      #1;
      check($sformatf("arb round %0d resp", r), {62'd0, if0.rs_valid, if1.rs_valid},
            (r % 2 == 0) ? 64'd2 : 64'd1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("arb no stats", {60'd0, hit_cnt, miss_cnt}, 64'd0);

    // Port 0 read hit, c_done three cycles after accept.
    txn("p0 read hit", 1'b0, 1'b0, 32'h0, 32'h0, 3, 1'b1, 1'b0, 32'hCAFE_BABE, 1'b0, 4, 1'b0);
    check("p0 read hit cnt", {60'd0, hit_cnt, miss_cnt}, {60'd0, 2'd1, 2'd0});

    // Port 1 write miss.
    txn("p1 write miss", 1'b1, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 2, 1'b0, 1'b1,
        32'h1234_5678, 1'b0, 3, 1'b0);
    check("p1 write miss cnt", {60'd0, hit_cnt, miss_cnt}, {60'd0, 2'd1, 2'd1});

    // Watchdog abort, then completion on the watchdog's final cycle.
    txn("timeout", 1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 9, 1'b0);
    check("timeout cnt", {60'd0, hit_cnt, miss_cnt}, {60'd0, 2'd1, 2'd1});
    txn("done at 8", 1'b1, 1'b0, 32'h44, 32'h0, 8, 1'b1, 1'b0, 32'h55AA_55AA, 1'b0, 9, 1'b0);
    check("done at 8 cnt", {60'd0, hit_cnt, miss_cnt}, {60'd0, 2'd2, 2'd1});

    // Statistics clear and saturation.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr", {60'd0, hit_cnt, miss_cnt}, 64'd0);
    for (int n = 0; n < 5; n++)
      txn("sat hit", 1'b0, 1'b0, 32'h80, 32'h0, 1, 1'b1, 1'b0, 32'h0000_0A0A, 1'b0, 2, 1'b0);
    check("sat hit_cnt", {62'd0, hit_cnt}, 64'd3);
    txn("clr vs hit", 1'b0, 1'b0, 32'h84, 32'h0, 1, 1'b1, 1'b0, 32'h7, 1'b0, 2, 1'b1);
    check("clr vs hit cnt", {62'd0, hit_cnt}, 64'd0);
    txn("hit after clr", 1'b0, 1'b0, 32'h88, 32'h0, 1, 1'b1, 1'b0, 32'h9, 1'b0, 2, 1'b0);
    check("hit after clr cnt", {62'd0, hit_cnt}, 64'd1);

    // Reset while BUSY: command drops at once and no response appears.
    drive(1'b0, 1'b1, 1'b0, 32'hC0, 32'h0);
    #1;
    check("rst txn ready", {63'd0, if0.rq_ready}, 64'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst txn busy", {63'd0, c_read}, 64'd1);
    tick();
    #2 rst_b = 1'b0;
    #1;
    check("rst async cmd", {62'd0, c_read, c_write}, 64'd0);
    c_done = 1'b1; c_hit = 1'b1;
    tick(); tick();
    c_done = 1'b0; c_hit = 1'b0;
    rst_b = 1'b1;
    #1;
    check("rst no resp a", {62'd0, if0.rs_valid, if1.rs_valid}, 64'd0);
    tick();
    check("rst no resp b", {62'd0, if0.rs_valid, if1.rs_valid}, 64'd0);
    check("rst counters", {60'd0, hit_cnt, miss_cnt}, 64'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    check("post rst grant", {62'd0, if0.rq_ready, if1.rq_ready}, 64'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
